param_updown_counter: RTL

Parametrised synchronous up/down counter. It is the next generation of the team's fixed 4-bit free-running counter, adding configurable width, a programmable modulus, wrap or saturate mode, count enable, direction control, parallel load, synchronous clear and status outputs. It is intended as the general counting primitive for timers, dividers and cascaded counter chains. A terminal-count output is provided for chaining multiple instances.

---
 rtl/param_updown_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus, wrap or
// saturate behaviour, parallel load, synchronous clear and cascade output.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam bit FULL_RANGE = (MAX_VAL == {WIDTH{1'b1}});

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] din_clamped;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == MAX_VAL);
    assign at_zero = (cnt_q == '0);

    // With a full-range modulus no din can exceed MAX_VAL, so skip the compare.
    if (FULL_RANGE) begin : g_no_clamp
        assign din_clamped = din;
    end else begin : g_clamp
        assign din_clamped = (din > MAX_VAL) ? MAX_VAL : din;
    end

    // Next-state selection in priority order clr > load > en > hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = din_clamped;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= RST_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Zero-latency terminal count so a chained stage steps on the same edge.
    assign tc   = en & ((up & at_max) | (~up & at_zero));
    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule
